// File: rtl/eoc_ctrl_regs_pkg.sv
// eoc_ctrl_regs_pkg: shared register offsets, response codes, FSM states
// and helpers for the end-of-computation register block.
// Optional cycle counter is enabled with EOC_CTRL_REGS_CYCLE_CNT_EN.
package eoc_ctrl_regs_pkg;

   localparam logic [7:0] EXIT_OFF          = 8'h00;
   localparam logic [7:0] EVENT_TRIGGER_OFF = 8'h08;
   localparam logic [7:0] DRAM_BASE_OFF     = 8'h10;
   localparam logic [7:0] DRAM_END_OFF      = 8'h18;
   localparam logic [7:0] CYCLE_CNT_OFF     = 8'h20;

   localparam logic [63:0] VCD_TRIGGER_ON  = 64'h1;
   localparam logic [63:0] VCD_TRIGGER_OFF = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10
   } resp_t;

   typedef enum logic {
      W_IDLE,
      W_RESP
   } w_state_t;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } r_state_t;

   typedef enum logic [2:0] {
      REG_EXIT,
      REG_EVENT,
      REG_DRAM_BASE,
      REG_DRAM_END,
      REG_CYCLE_CNT
   } reg_idx_t;

   // Byte-lane merge of new write data into the old register value.
   function automatic logic [63:0] strb_merge(input logic [63:0] old_val,
                                              input logic [63:0] wdata,
                                              input logic [7:0]  strb);
      logic [63:0] res;
      res = old_val;
      for (int unsigned i = 0; i < 8; i++) begin
         if (strb[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/eoc_ctrl_regs_if.sv
// eoc_ctrl_regs_if: AXI4-Lite channel bundle for the EOC register block.
interface eoc_ctrl_regs_if #(
   parameter int unsigned AxiAddrWidth = 64
) ();

   logic [AxiAddrWidth-1:0] aw_addr_i;
   logic                    aw_valid_i;
   logic                    aw_ready_o;
   logic [63:0]             w_data_i;
   logic [7:0]              w_strb_i;
   logic                    w_valid_i;
   logic                    w_ready_o;
   logic [1:0]              b_resp_o;
   logic                    b_valid_o;
   logic                    b_ready_i;
   logic [AxiAddrWidth-1:0] ar_addr_i;
   logic                    ar_valid_i;
   logic                    ar_ready_o;
   logic [63:0]             r_data_o;
   logic [1:0]              r_resp_o;
   logic                    r_valid_o;
   logic                    r_ready_i;

   modport slave (
      input  aw_addr_i, aw_valid_i, w_data_i, w_strb_i, w_valid_i, b_ready_i,
      input  ar_addr_i, ar_valid_i, r_ready_i,
      output aw_ready_o, w_ready_o, b_resp_o, b_valid_o,
      output ar_ready_o, r_data_o, r_resp_o, r_valid_o
   );

   modport master (
      output aw_addr_i, aw_valid_i, w_data_i, w_strb_i, w_valid_i, b_ready_i,
      output ar_addr_i, ar_valid_i, r_ready_i,
      input  aw_ready_o, w_ready_o, b_resp_o, b_valid_o,
      input  ar_ready_o, r_data_o, r_resp_o, r_valid_o
   );

endinterface

// File: rtl/eoc_reg_decode.sv
// eoc_reg_decode: maps a byte offset to a register index plus
// valid/writable flags. Offset 0x20 exists only with
// EOC_CTRL_REGS_CYCLE_CNT_EN defined.
module eoc_reg_decode
   import eoc_ctrl_regs_pkg::*;
(
   input  logic [7:0] offset,
   output reg_idx_t   index,
   output logic       valid,
   output logic       writable
);

   // Offset decode; misaligned or unknown offsets are invalid.
   always_comb begin
      index    = REG_EXIT;
      valid    = 1'b0;
      writable = 1'b0;
      case (offset)
         EXIT_OFF: begin
            index = REG_EXIT; valid = 1'b1; writable = 1'b1;
         end
         EVENT_TRIGGER_OFF: begin
            index = REG_EVENT; valid = 1'b1; writable = 1'b1;
         end
         DRAM_BASE_OFF: begin
            index = REG_DRAM_BASE; valid = 1'b1;
         end
         DRAM_END_OFF: begin
            index = REG_DRAM_END; valid = 1'b1;
         end
`ifdef EOC_CTRL_REGS_CYCLE_CNT_EN
         CYCLE_CNT_OFF: begin
            index = REG_CYCLE_CNT; valid = 1'b1;
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/eoc_ctrl_regs.sv
// eoc_ctrl_regs: AXI4-Lite register responder holding the EXIT word,
// the VCD event trigger, read-only DRAM bounds and (when
// EOC_CTRL_REGS_CYCLE_CNT_EN is defined) a free-running cycle counter.
module eoc_ctrl_regs
   import eoc_ctrl_regs_pkg::*;
#(
   parameter int unsigned AxiAddrWidth = 64,
   parameter int unsigned AxiDataWidth = 64,
   parameter logic [63:0] DRAMBase     = 64'h8000_0000,
   parameter logic [63:0] DRAMLength   = 64'h4000_0000
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   eoc_ctrl_regs_if.slave    bus,
   output logic [63:0]       exit_o,
   output logic [63:0]       event_trigger_o
);

   if (AxiDataWidth != 64) begin : g_bad_data_width
      $error("eoc_ctrl_regs: AxiDataWidth must be 64");
   end

   localparam logic [63:0] DRAM_END = DRAMBase + DRAMLength;

   w_state_t    w_state, w_next;
   r_state_t    r_state, r_next;
   logic        w_hs, ar_hs;
   reg_idx_t    w_idx, r_idx;
   logic        w_valid_dec, w_writable, r_valid_dec, r_writable;
   logic [63:0] exit_q, event_q, rd_val, r_data_q;
   resp_t       b_resp_q, r_resp_q;
   logic        unused_bits;

   assign unused_bits = ^{bus.aw_addr_i[AxiAddrWidth-1:8],
                          bus.ar_addr_i[AxiAddrWidth-1:8], r_writable};

   eoc_reg_decode u_w_dec (
      .offset   (bus.aw_addr_i[7:0]),
      .index    (w_idx),
      .valid    (w_valid_dec),
      .writable (w_writable)
   );

   eoc_reg_decode u_r_dec (
      .offset   (bus.ar_addr_i[7:0]),
      .index    (r_idx),
      .valid    (r_valid_dec),
      .writable (r_writable)
   );

`ifdef EOC_CTRL_REGS_CYCLE_CNT_EN
   logic [63:0] cycle_q;

   // Free-running cycle counter, wraps naturally at 2^64.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cycle_q <= '0;
      else         cycle_q <= cycle_q + 64'd1;
   end
`endif

   // Write and read FSM state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         w_state <= W_IDLE;
         r_state <= R_IDLE;
      end else begin
         w_state <= w_next;
         r_state <= r_next;
      end
   end

   // Write FSM: AW and W must both be valid to handshake together.
   always_comb begin
      w_next         = w_state;
      w_hs           = 1'b0;
      bus.aw_ready_o = 1'b0;
      bus.w_ready_o  = 1'b0;
      bus.b_valid_o  = 1'b0;
      case (w_state)
         W_IDLE: begin
            w_hs           = bus.aw_valid_i & bus.w_valid_i;
            bus.aw_ready_o = w_hs;
            bus.w_ready_o  = w_hs;
            if (w_hs) w_next = W_RESP;
         end
         W_RESP: begin
            bus.b_valid_o = 1'b1;
            if (bus.b_ready_i) w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   // Read FSM; ar_ready is held low while reset is asserted.
   always_comb begin
      r_next         = r_state;
      ar_hs          = 1'b0;
      bus.ar_ready_o = 1'b0;
      bus.r_valid_o  = 1'b0;
      case (r_state)
         R_IDLE: begin
            bus.ar_ready_o = rst_ni;
            ar_hs          = rst_ni & bus.ar_valid_i;
            if (ar_hs) r_next = R_DATA;
         end
         R_DATA: begin
            bus.r_valid_o = 1'b1;
            if (bus.r_ready_i) r_next = R_IDLE;
         end
         default: r_next = R_IDLE;
      endcase
   end

   // Register write path; EXIT locks once its done bit is set.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         exit_q   <= '0;
         event_q  <= '0;
         b_resp_q <= OKAY;
      end else if (w_hs) begin
         if (!w_valid_dec || !w_writable) begin
            b_resp_q <= SLVERR;
         end else begin
            b_resp_q <= OKAY;
            case (w_idx)
               REG_EXIT:
                  if (!exit_q[0]) exit_q <= strb_merge(exit_q, bus.w_data_i, bus.w_strb_i);
               REG_EVENT:
                  event_q <= strb_merge(event_q, bus.w_data_i, bus.w_strb_i);
               default: ;
            endcase
         end
      end
   end

   // Read data mux using pre-write register values.
   always_comb begin
      rd_val = '0;
      case (r_idx)
         REG_EXIT:      rd_val = exit_q;
         REG_EVENT:     rd_val = event_q;
         REG_DRAM_BASE: rd_val = DRAMBase;
         REG_DRAM_END:  rd_val = DRAM_END;
`ifdef EOC_CTRL_REGS_CYCLE_CNT_EN
         REG_CYCLE_CNT: rd_val = cycle_q;
`endif
         default:       rd_val = '0;
      endcase
   end

   // Capture read response at the AR handshake; held until accepted.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_data_q <= '0;
         r_resp_q <= OKAY;
      end else if (ar_hs) begin
         r_data_q <= r_valid_dec ? rd_val : '0;
         r_resp_q <= r_valid_dec ? OKAY : SLVERR;
      end
   end

   assign bus.b_resp_o    = b_resp_q;
   assign bus.r_data_o    = r_data_q;
   assign bus.r_resp_o    = r_resp_q;
   assign exit_o          = exit_q;
   assign event_trigger_o = event_q;

endmodule

// File: tb/tb_eoc_ctrl_regs.sv
// tb_eoc_ctrl_regs: table-driven AXI4-Lite bench for eoc_ctrl_regs with a
// response scoreboard and hand-written multi-cycle corner cases.
// Cycle counter checks depend on EOC_CTRL_REGS_CYCLE_CNT_EN.
module tb_eoc_ctrl_regs;
   import eoc_ctrl_regs_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] exit_w, evt_w;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   eoc_ctrl_regs_if #(.AxiAddrWidth(64)) bus ();

   eoc_ctrl_regs #(
      .AxiAddrWidth (64),
      .AxiDataWidth (64),
      .DRAMBase     (64'h8000_0000),
      .DRAMLength   (64'h4000_0000)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .bus             (bus.slave),
      .exit_o          (exit_w),
      .event_trigger_o (evt_w)
   );

   typedef struct {
      bit          is_wr;
      logic [63:0] addr;
      logic [63:0] data;
      logic [7:0]  strb;
      resp_t       resp;
      logic [63:0] rdata;
      bit          chk_rdata;
      logic [63:0] exp_exit;
      logic [63:0] exp_evt;
   } vec_t;

   typedef struct {
      logic [1:0]  resp;
      logic [63:0] data;
      bit          chk_data;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_valid(input string name, input bit is_b);
      int n = 0;
      while (((is_b ? bus.b_valid_o : bus.r_valid_o) !== 1'b1) && n < 8) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, "_timeout"}, is_b ? bus.b_valid_o : bus.r_valid_o, 64'h1);
   endtask

   task automatic pop_exp(input string name, output exp_t e);
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s_sb: got empty scoreboard expected an entry", name);
         e = '{2'b00, 64'h0, 1'b0};
      end else begin
         e = sb.pop_front();
      end
   endtask

   task automatic do_write(input string name, input logic [63:0] a, input logic [63:0] d,
                           input logic [7:0] s, input resp_t er);
      exp_t e;
      bus.aw_addr_i  = a;
      bus.w_data_i   = d;
      bus.w_strb_i   = s;
      bus.aw_valid_i = 1'b1;
      bus.w_valid_i  = 1'b1;
      bus.b_ready_i  = 1'b1;
      sb.push_back('{er, 64'h0, 1'b0});
      #1;
      check({name, "_awready"}, bus.aw_ready_o, 64'h1);
      @(posedge clk); #1;
      bus.aw_valid_i = 1'b0;
      bus.w_valid_i  = 1'b0;
      check({name, "_blat"}, bus.b_valid_o, 64'h1);
      if (bus.b_valid_o !== 1'b1) wait_valid(name, 1'b1);
      pop_exp(name, e);
      check({name, "_bresp"}, bus.b_resp_o, e.resp);
      @(posedge clk); #1;
   endtask

   task automatic do_read(input string name, input logic [63:0] a,
                          input resp_t er, input logic [63:0] ed, input bit chk);
      exp_t e;
      bus.ar_addr_i  = a;
      bus.ar_valid_i = 1'b1;
      bus.r_ready_i  = 1'b1;
      sb.push_back('{er, ed, chk});
      @(posedge clk); #1;
      bus.ar_valid_i = 1'b0;
      check({name, "_rlat"}, bus.r_valid_o, 64'h1);
      if (bus.r_valid_o !== 1'b1) wait_valid(name, 1'b0);
      pop_exp(name, e);
      check({name, "_rresp"}, bus.r_resp_o, e.resp);
      if (e.chk_data) check({name, "_rdata"}, bus.r_data_o, e.data);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0] c1;
      resp_t       cyc_resp;
      bit          cyc_chk;
`ifdef EOC_CTRL_REGS_CYCLE_CNT_EN
      cyc_resp = OKAY;   cyc_chk = 1'b0;
`else
      cyc_resp = SLVERR; cyc_chk = 1'b1;
`endif
      bus.aw_addr_i = '0; bus.aw_valid_i = 1'b0; bus.w_data_i = '0; bus.w_strb_i = '0;
      bus.w_valid_i = 1'b0; bus.b_ready_i = 1'b0; bus.ar_addr_i = '0;
      bus.ar_valid_i = 1'b0; bus.r_ready_i = 1'b0;

      //             wr addr        data                   strb   resp    rdata          chk  exit   evt
      vecs.push_back('{0, 64'h00,   64'h0,                 8'h00, OKAY,   64'h0,         1, 64'h0, 64'h0});
      vecs.push_back('{1, 64'h08,   64'h1,                 8'hFF, OKAY,   64'h0,         0, 64'h0, 64'h1});
      vecs.push_back('{1, 64'h08,   64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, OKAY, 64'h0,         0, 64'h0, 64'hFFFF_FFFF});
      vecs.push_back('{0, 64'h08,   64'h0,                 8'h00, OKAY,   64'hFFFF_FFFF, 1, 64'h0, 64'hFFFF_FFFF});
      vecs.push_back('{0, 64'h10,   64'h0,                 8'h00, OKAY,   64'h8000_0000, 1, 64'h0, 64'hFFFF_FFFF});
      vecs.push_back('{0, 64'h18,   64'h0,                 8'h00, OKAY,   64'hC000_0000, 1, 64'h0, 64'hFFFF_FFFF});
      vecs.push_back('{1, 64'h10,   64'h5,                 8'hFF, SLVERR, 64'h0,         0, 64'h0, 64'hFFFF_FFFF});
      vecs.push_back('{1, 64'h28,   64'h5,                 8'hFF, SLVERR, 64'h0,         0, 64'h0, 64'hFFFF_FFFF});
      vecs.push_back('{0, 64'h04,   64'h0,                 8'h00, SLVERR, 64'h0,         1, 64'h0, 64'hFFFF_FFFF});
      vecs.push_back('{0, 64'h10,   64'h0,                 8'h00, OKAY,   64'h8000_0000, 1, 64'h0, 64'hFFFF_FFFF});
      vecs.push_back('{1, 64'h0C,   64'h3,                 8'hFF, SLVERR, 64'h0,         0, 64'h0, 64'hFFFF_FFFF});
      vecs.push_back('{1, 64'h00,   64'h7,                 8'hFF, OKAY,   64'h0,         0, 64'h7, 64'hFFFF_FFFF});
      vecs.push_back('{1, 64'h00,   64'h1,                 8'hFF, OKAY,   64'h0,         0, 64'h7, 64'hFFFF_FFFF});
      vecs.push_back('{0, 64'h00,   64'h0,                 8'h00, OKAY,   64'h7,         1, 64'h7, 64'hFFFF_FFFF});
      vecs.push_back('{0, 64'h118,  64'h0,                 8'h00, OKAY,   64'hC000_0000, 1, 64'h7, 64'hFFFF_FFFF});
      vecs.push_back('{1, 64'h08,   64'hABCD,              8'h00, OKAY,   64'h0,         0, 64'h7, 64'hFFFF_FFFF});
      vecs.push_back('{1, 64'h20,   64'h5,                 8'hFF, SLVERR, 64'h0,         0, 64'h7, 64'hFFFF_FFFF});
      vecs.push_back('{0, 64'h20,   64'h0,                 8'h00, cyc_resp, 64'h0,       cyc_chk, 64'h7, 64'hFFFF_FFFF});

      // Reset state
      #3;
      check("rst_awready", bus.aw_ready_o, 64'h0);
      check("rst_wready",  bus.w_ready_o,  64'h0);
      check("rst_arready", bus.ar_ready_o, 64'h0);
      check("rst_bvalid",  bus.b_valid_o,  64'h0);
      check("rst_rvalid",  bus.r_valid_o,  64'h0);
      check("rst_bresp",   bus.b_resp_o,   64'h0);
      check("rst_rresp",   bus.r_resp_o,   64'h0);
      check("rst_rdata",   bus.r_data_o,   64'h0);
      check("rst_exit",    exit_w,         64'h0);
      check("rst_evt",     evt_w,          64'h0);
      #9 rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle_arready", bus.ar_ready_o, 64'h1);

      for (int i = 0; i < vecs.size(); i++) begin
         string nm;
         nm = $sformatf("v%0d", i);
         if (vecs[i].is_wr)
            do_write(nm, vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp);
         else
            do_read(nm, vecs[i].addr, vecs[i].resp, vecs[i].rdata, vecs[i].chk_rdata);
         check({nm, "_exit"}, exit_w, vecs[i].exp_exit);
         check({nm, "_evt"},  evt_w,  vecs[i].exp_evt);
      end

      // Same-cycle read and write of EVENT_TRIGGER: read sees old value
      bus.aw_addr_i = 64'h08; bus.w_data_i = 64'h1234; bus.w_strb_i = 8'hFF;
      bus.aw_valid_i = 1'b1; bus.w_valid_i = 1'b1; bus.b_ready_i = 1'b1;
      bus.ar_addr_i = 64'h08; bus.ar_valid_i = 1'b1; bus.r_ready_i = 1'b1;
      @(posedge clk); #1;
      bus.aw_valid_i = 1'b0; bus.w_valid_i = 1'b0; bus.ar_valid_i = 1'b0;
      check("rw_rvalid", bus.r_valid_o, 64'h1);
      check("rw_rdata",  bus.r_data_o,  64'hFFFF_FFFF);
      check("rw_bvalid", bus.b_valid_o, 64'h1);
      check("rw_bresp",  bus.b_resp_o,  64'h0);
      check("rw_evt",    evt_w,         64'h1234);
      @(posedge clk); #1;

      // Read DRAM_END with r_ready low for 3 cycles
      bus.ar_addr_i = 64'h18; bus.ar_valid_i = 1'b1; bus.r_ready_i = 1'b0;
      @(posedge clk); #1;
      bus.ar_valid_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("stall%0d_rvalid", k), bus.r_valid_o, 64'h1);
         check($sformatf("stall%0d_rdata", k),  bus.r_data_o,  64'hC000_0000);
         check($sformatf("stall%0d_rresp", k),  bus.r_resp_o,  64'h0);
         @(posedge clk); #1;
      end
      bus.r_ready_i = 1'b1;
      @(posedge clk); #1;
      check("stall_release", bus.r_valid_o, 64'h0);

`ifdef EOC_CTRL_REGS_CYCLE_CNT_EN
      // Two CYCLE_CNT reads with AR handshakes 10 cycles apart
      bus.ar_addr_i = 64'h20; bus.ar_valid_i = 1'b1;
      @(posedge clk); #1;
      bus.ar_valid_i = 1'b0;
      check("cyc1_rresp", bus.r_resp_o, 64'h0);
      c1 = bus.r_data_o;
      repeat (9) @(posedge clk);
      #1;
      bus.ar_valid_i = 1'b1;
      @(posedge clk); #1;
      bus.ar_valid_i = 1'b0;
      check("cyc2_rresp", bus.r_resp_o, 64'h0);
      check("cyc_diff", bus.r_data_o - c1, 64'd10);
      @(posedge clk); #1;
`else
      c1 = '0;
`endif

      // Fresh reset, then EXIT = 1 reports success
      rst_n = 1'b0; #2; rst_n = 1'b1;
      @(posedge clk); #1;
      do_write("exit1", 64'h00, 64'h1, 8'hFF, OKAY);
      check("exit1_val", exit_w, 64'h1);

      // Reset pulse while b_valid is pending
      bus.aw_addr_i = 64'h08; bus.w_data_i = 64'h5; bus.w_strb_i = 8'hFF;
      bus.aw_valid_i = 1'b1; bus.w_valid_i = 1'b1; bus.b_ready_i = 1'b0;
      @(posedge clk); #1;
      bus.aw_valid_i = 1'b0; bus.w_valid_i = 1'b0;
      check("hold_bvalid", bus.b_valid_o, 64'h1);
      check("hold_evt",    evt_w,         64'h5);
      @(posedge clk); #1;
      check("hold2_bvalid", bus.b_valid_o, 64'h1);
      check("hold2_bresp",  bus.b_resp_o,  64'h0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_bvalid", bus.b_valid_o, 64'h0);
      check("arst_exit",   exit_w,        64'h0);
      check("arst_evt",    evt_w,         64'h0);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_bvalid", bus.b_valid_o, 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/eoc_ctrl_regs.md
Name: eoc_ctrl_regs

Overview:
- AXI4-Lite register responder inside ara_soc, written by the scalar core through the peripheral crossbar.
- Produces the end-of-computation word `exit_o` and the VCD trigger `event_trigger_o`; the testbench consumes both.
- Also exposes read-only DRAM bounds and a cycle counter, so software can size its buffers and time regions.

Parameters:
- AxiAddrWidth, 64, AXI address width.
- AxiDataWidth, 64, AXI data width; only 64 is legal (elaboration-time assertion).
- DRAMBase, 64'h8000_0000, value of DRAM_BASE register.
- DRAMLength, 64'h4000_0000, DRAM size; DRAM_END reads DRAMBase+DRAMLength.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- aw_addr_i  in  AxiAddrWidth  write address
- aw_valid_i  in  1  write address valid
- aw_ready_o  out  1  write address ready
- w_data_i  in  64  write data
- w_strb_i  in  8  byte strobes
- w_valid_i  in  1  write data valid
- w_ready_o  out  1  write data ready
- b_resp_o  out  2  write response (00 OKAY, 10 SLVERR)
- b_valid_o  out  1  write response valid
- b_ready_i  in  1  write response ready
- ar_addr_i  in  AxiAddrWidth  read address
- ar_valid_i  in  1  read address valid
- ar_ready_o  out  1  read address ready
- r_data_o  out  64  read data
- r_resp_o  out  2  read response
- r_valid_o  out  1  read data valid
- r_ready_i  in  1  read data ready
- exit_o  out  64  EXIT register; bit0 = done, [63:1] = tohost code
- event_trigger_o  out  64  EVENT_TRIGGER register

Behaviour:
- Register map (offset = addr[7:0]; upper address bits ignored):
  - 0x00 EXIT, RW, sticky once bit0 is set.
  - 0x08 EVENT_TRIGGER, RW.
  - 0x10 DRAM_BASE, RO.
  - 0x18 DRAM_END, RO.
  - 0x20 CYCLE_CNT, RO.
- Error responses:
  - Unmapped offset or addr[2:0] != 0 -> SLVERR; no state change; read data 0.
  - Write to an RO register -> SLVERR; value unchanged.
- Reset values: all ready/valid outputs 0; resp 00; r_data_o 0; exit_o 0; event_trigger_o 0; write FSM W_IDLE; read FSM R_IDLE.
- Write FSM, W_IDLE:
  - aw_ready_o = w_ready_o = aw_valid_i & w_valid_i; both handshake in the same cycle; a lone AW or W waits.
  - On the handshake, apply the strobe-masked write at that edge and go to W_RESP.
- Write FSM, W_RESP:
  - b_valid_o = 1, b_resp_o stable; both ready outputs 0.
  - Leave to W_IDLE when b_ready_i = 1.
- Write latency: write handshake at cycle N -> register updated and b_valid_o high at N+1.
- EXIT stickiness: when exit_o[0] = 1, later EXIT writes are dropped but still answered OKAY. exit_o holds until reset.
- Read FSM, R_IDLE:
  - ar_ready_o = 1.
  - On ar handshake, register r_data_o/r_resp_o and go to R_DATA.
- Read FSM, R_DATA:
  - r_valid_o = 1; data stable while r_ready_i = 0.
  - Return to R_IDLE on r_ready_i.
- Read latency: AR at N -> r_valid_o at N+1.
- Simultaneous read and write to the same register in the same cycle: read returns the pre-write value.
- CYCLE_CNT (feature enabled): increments every cycle from reset, wraps from 2^64-1 to 0. Read value = counter at the AR handshake edge.
- Reset asserted mid-transaction: FSMs return to idle, valid outputs drop asynchronously, registers clear; the in-flight transaction is lost.

Optional Feature:
- Macro: EOC_CTRL_REGS_CYCLE_CNT_EN.
- Defined: 64-bit free-running CYCLE_CNT at offset 0x20.
- Undefined: no counter flops; 0x20 is unmapped and returns SLVERR.

Decomposition:
- Package eoc_ctrl_regs_pkg holds:
  - register offset localparams (EXIT_OFF, EVENT_TRIGGER_OFF, DRAM_BASE_OFF, DRAM_END_OFF, CYCLE_CNT_OFF);
  - resp_t enum (OKAY = 2'b00, SLVERR = 2'b10);
  - write and read FSM state enums;
  - VCD_TRIGGER_ON = 64'h1 and VCD_TRIGGER_OFF = 64'hFFFF_FFFF_FFFF_FFFF.
- Sub-module eoc_reg_decode: combinational offset -> {index, valid, writable}, shared by the read and write paths.

Test Plan:
- Write 0x00 = 64'h1, strb 8'hFF -> b_resp 00 at N+1; exit_o = 64'h1 (testbench reports SUCCESS, tohost 0).
- Write 0x00 = 64'h7, then 0x00 = 64'h1 -> exit_o stays 64'h7 (tohost 3); both writes answered OKAY.
- Write 0x08 = 64'h1, then 0x08 = 64'hFFFF_FFFF_FFFF_FFFF, strb 8'h0F -> event_trigger_o = 64'h0000_0000_FFFF_FFFF.
- Read 0x18, r_ready held low 3 cycles -> r_data = 64'hC000_0000 stable throughout; r_resp 00.
- Write 0x10, write 0x28, read 0x04 -> all SLVERR; no register changes; read data 0.
- Read 0x20 twice, 10 cycles apart (feature on) -> difference 10. Feature off -> SLVERR. Reset pulse while b_valid high -> b_valid 0 and exit_o 0 immediately.
